// File: rtl/axil_aw_fifo_if.sv
// axil_aw_fifo_if: one AXI4-Lite write-address channel (VALID/READY, AWADDR, AWPROT).
interface axil_aw_fifo_if #(parameter int ADDR_WIDTH = 32);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  modport master (output awvalid, awaddr, awprot, input awready);
  modport slave  (input awvalid, awaddr, awprot, output awready);
endinterface

// File: rtl/axil_aw_fifo.sv
// axil_aw_fifo: DEPTH-entry first-word-fall-through AW channel buffer with output address
// alignment, a sticky misalignment flag and an occupancy count.
module axil_aw_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ALIGN_LSBS = 2
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  axil_aw_fifo_if.slave                s,
  axil_aw_fifo_if.master               m,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         misalign_err,
  input  logic                         misalign_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] MASK = ~((ADDR_WIDTH'(1) << ALIGN_LSBS) - ADDR_WIDTH'(1));
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [2:0]            r_prot [DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_s_ready, r_m_valid, r_err;
  logic                  w_push, w_pop, w_mis;
  logic [LW-1:0]         w_count_next;
  assign w_push       = s.awvalid && r_s_ready;
  assign w_pop        = r_m_valid && m.awready;
  assign w_count_next = r_level + LW'(w_push) - LW'(w_pop);
  // bits outside MASK are the alignment LSBs; empty when ALIGN_LSBS is 0
  assign w_mis        = (s.awaddr & ~MASK) != '0;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_prot[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr] <= s.awaddr;
        r_prot[r_wr_ptr] <= s.awprot;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level   <= w_count_next;
      r_s_ready <= w_count_next != LW'(DEPTH);
      r_m_valid <= w_count_next != '0;
      r_err     <= misalign_clr ? 1'b0 : (r_err | (w_push && w_mis));
    end
  end
  assign s.awready    = r_s_ready;
  assign m.awvalid    = r_m_valid;
  assign m.awaddr     = r_addr[r_rd_ptr] & MASK;
  assign m.awprot     = r_prot[r_rd_ptr];
  assign level        = r_level;
  assign misalign_err = r_err;
endmodule

// File: tb/tb_axil_aw_fifo.sv
// tb_axil_aw_fifo: directed and random stimulus checked against a queue-based model.
module tb_axil_aw_fifo;
  localparam int DEPTH = 4;
  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [2:0] level;
  logic       misalign_err;
  logic       misalign_clr;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 ACLK = ~ACLK;
  axil_aw_fifo_if #(.ADDR_WIDTH(32)) s_if ();
  axil_aw_fifo_if #(.ADDR_WIDTH(32)) m_if ();
  axil_aw_fifo #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .ALIGN_LSBS(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .s(s_if), .m(m_if),
    .level(level), .misalign_err(misalign_err), .misalign_clr(misalign_clr)
  );
  // reference: a queue of {addr, prot}; flags are the registered view of its size
  logic [34:0] q [$];
  logic        e_rdy, e_vld, e_err;
  logic        m_push, m_pop, m_mis;
  assign m_push = s_if.awvalid && e_rdy;
  assign m_pop  = e_vld && m_if.awready;
  assign m_mis  = m_push && (s_if.awaddr[1:0] != 2'b00);
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      q.delete();
      e_rdy <= 1'b0;
      e_vld <= 1'b0;
      e_err <= 1'b0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({s_if.awaddr, s_if.awprot});
      e_rdy <= q.size() != DEPTH;
      e_vld <= q.size() != 0;
      e_err <= misalign_clr ? 1'b0 : (e_err | m_mis);
    end
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
    check("s_awready", s_if.awready, e_rdy);
    check("m_awvalid", m_if.awvalid, e_vld);
    check("level", level, q.size());
    check("misalign_err", misalign_err, e_err);
    if (e_vld) begin
      check("m_awaddr", m_if.awaddr, {q[0][34:5], 2'b00});
      check("m_awprot", m_if.awprot, q[0][2:0]);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [2:0] p);
    s_if.awvalid = v;
    s_if.awaddr  = a;
    s_if.awprot  = p;
  endtask
  initial begin
    drive(1'b0, 32'h0, 3'h0);
    m_if.awready = 1'b0;
    misalign_clr = 1'b0;
    repeat (3) begin
      @(posedge ACLK);
      #1;
      check("rst_awready", s_if.awready, 0);
      check("rst_awvalid", m_if.awvalid, 0);
      check("rst_level", level, 0);
      check("rst_err", misalign_err, 0);
      check("rst_awaddr", m_if.awaddr, 0);
      check("rst_awprot", m_if.awprot, 0);
    end
    ARESETn = 1'b1;
    tick();
    check("rdy_after_rst", s_if.awready, 1);
    // single transfer
    drive(1'b1, 32'h0000_1004, 3'b010);
    tick();
    drive(1'b0, 32'h0, 3'h0);
    check("single_vld", m_if.awvalid, 1);
    check("single_addr", m_if.awaddr, 32'h0000_1004);
    check("single_prot", m_if.awprot, 3'b010);
    check("single_level", level, 1);
    m_if.awready = 1'b1;
    tick();
    check("single_pop_vld", m_if.awvalid, 0);
    m_if.awready = 1'b0;
    // fill to full, hold a fifth push, then pop one
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i * 16), 3'(i));
      tick();
    end
    check("full_level", level, 4);
    check("full_rdy", s_if.awready, 0);
    drive(1'b1, 32'h50, 3'h5);
    repeat (3) begin
      tick();
      check("full_hold_level", level, 4);
    end
    drive(1'b0, 32'h0, 3'h0);
    m_if.awready = 1'b1;
    tick();
    m_if.awready = 1'b0;
    check("after_pop_rdy", s_if.awready, 1);
    check("after_pop_head", m_if.awaddr, 32'h20);
    m_if.awready = 1'b1;
    repeat (3) tick();
    // streaming with 1-cycle latency
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 3'(i));
      tick();
      check("stream_level", level, 1);
      check("stream_head", m_if.awaddr, 32'h100 + 32'(i * 4));
    end
    drive(1'b0, 32'h0, 3'h0);
    tick();
    check("stream_drained", m_if.awvalid, 0);
    m_if.awready = 1'b0;
    // misalignment flag
    drive(1'b1, 32'h0000_2003, 3'h1);
    tick();
    check("mis_addr", m_if.awaddr, 32'h0000_2000);
    check("mis_set", misalign_err, 1);
    drive(1'b1, 32'h0000_2007, 3'h2);
    misalign_clr = 1'b1;
    tick();
    misalign_clr = 1'b0;
    check("mis_clr_wins", misalign_err, 0);
    drive(1'b1, 32'h0000_2008, 3'h3);
    tick();
    check("mis_aligned", misalign_err, 0);
    drive(1'b0, 32'h0, 3'h0);
    m_if.awready = 1'b1;
    repeat (4) tick();
    // random traffic
    repeat (400) begin
      drive($urandom_range(9) < 7, $urandom, 3'($urandom_range(7)));
      m_if.awready = $urandom_range(3) != 0;
      misalign_clr = $urandom_range(9) == 0;
      tick();
    end
    drive(1'b0, 32'h0, 3'h0);
    misalign_clr = 1'b0;
    m_if.awready = 1'b1;
    repeat (6) tick();
    // asynchronous reset with three entries held
    m_if.awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA00 + 32'(i * 4), 3'(i));
      tick();
    end
    drive(1'b0, 32'h0, 3'h0);
    check("pre_rst_level", level, 3);
    #2 ARESETn = 1'b0;
    #1;
    check("async_vld", m_if.awvalid, 0);
    check("async_level", level, 0);
    check("async_rdy", s_if.awready, 0);
    #1 ARESETn = 1'b1;
    tick();
    m_if.awready = 1'b1;
    drive(1'b1, 32'hB00, 3'h6);
    tick();
    drive(1'b0, 32'h0, 3'h0);
    check("post_rst_head", m_if.awaddr, 32'hB00);
    tick();
    check("post_rst_empty", m_if.awvalid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
